// File: rtl/button_pair_sel.sv
// Button conditioning and operand-pair selection: sync, debounce, press pulses, and A/B pairing FSM.
// Optional expiry of a pending selection is built when BUTTON_PAIR_SEL_TIMEOUT_EN is defined.
module button_pair_sel #(
    parameter int N             = 10,
    parameter int IDX_W         = 4,
    parameter int DB_TICKS      = 4,
    parameter int TIMEOUT_TICKS = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sample_en,
    input  logic [N-1:0]     buttons,
    output logic [N-1:0]     press_pulse,
    output logic             sel_pending,
    output logic             pair_valid,
    input  logic             pair_ready,
    output logic [IDX_W-1:0] idx_a,
    output logic [IDX_W-1:0] idx_b,
    output logic             timeout
);

    localparam int CNT_W = (DB_TICKS > 1) ? $clog2(DB_TICKS) : 1;
    localparam int TO_W  = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS) : 1;

    if (N < 2 || N > 16 || (1 << IDX_W) < N || DB_TICKS < 1 || TIMEOUT_TICKS < 1) begin : g_bad_params
        $error("button_pair_sel: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HAVE_A = 2'd1,
        OUT    = 2'd2
    } state_t;

    logic [N-1:0]     sync_q1;
    logic [N-1:0]     sync_q2;
    logic [N-1:0]     stable;
    logic [N-1:0]     db_done;
    logic [CNT_W-1:0] db_cnt [N];

    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] idx_a_next;
    logic [IDX_W-1:0] idx_b_next;
    logic             pick_valid;
    logic [IDX_W-1:0] pick_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= buttons;
            sync_q2 <= sync_q1;
        end
    end

    // A button's new level is accepted on the DB_TICKS-th consecutive differing sample.
    always_comb begin
        db_done = '0;
        for (int i = 0; i < N; i++) begin
            db_done[i] = sample_en && (sync_q2[i] != stable[i]) &&
                         (db_cnt[i] == CNT_W'(DB_TICKS - 1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable      <= '0;
            press_pulse <= '0;
            for (int i = 0; i < N; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            press_pulse <= db_done & sync_q2;
            for (int i = 0; i < N; i++) begin
                if (sample_en) begin
                    if (sync_q2[i] == stable[i]) begin
                        db_cnt[i] <= '0;
                    end else if (db_done[i]) begin
                        stable[i] <= sync_q2[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 1'b1;
                    end
                end
            end
        end
    end

    // Lowest-index pulse wins when several buttons are accepted in the same cycle.
    always_comb begin
        pick_valid = |press_pulse;
        pick_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (press_pulse[i]) begin
                pick_idx = IDX_W'(i);
            end
        end
    end

`ifdef BUTTON_PAIR_SEL_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt;
    logic            expire;
    logic            timeout_q;
    logic            timeout_next;

    assign expire  = sample_en && (to_cnt == TO_W'(TIMEOUT_TICKS - 1));
    assign timeout = timeout_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt    <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_next;
            if (state != HAVE_A) begin
                to_cnt <= '0;
            end else if (sample_en) begin
                to_cnt <= to_cnt + 1'b1;
            end
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx_a <= '0;
            idx_b <= '0;
        end else begin
            state <= state_next;
            idx_a <= idx_a_next;
            idx_b <= idx_b_next;
        end
    end

    // Presses while a pair is on offer are ignored; a B press beats a same-cycle expiry.
    always_comb begin
        state_next   = state;
        idx_a_next   = idx_a;
        idx_b_next   = idx_b;
`ifdef BUTTON_PAIR_SEL_TIMEOUT_EN
        timeout_next = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    idx_a_next = pick_idx;
                    state_next = HAVE_A;
                end
            end
            HAVE_A: begin
                if (pick_valid) begin
                    if (pick_idx == idx_a) begin
                        state_next = IDLE;
                    end else begin
                        idx_b_next = pick_idx;
                        state_next = OUT;
                    end
                end
`ifdef BUTTON_PAIR_SEL_TIMEOUT_EN
                else if (expire) begin
                    state_next   = IDLE;
                    timeout_next = 1'b1;
                end
`endif
            end
            OUT: begin
                if (pair_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign sel_pending = (state != IDLE);
    assign pair_valid  = (state == OUT);

endmodule

// File: tb/tb_button_pair_sel.sv
// Directed testbench for button_pair_sel: debounce, pairing, backpressure, deselect and expiry.
// Define BUTTON_PAIR_SEL_TIMEOUT_EN for both bench and RTL to exercise the expiry path.
module tb_button_pair_sel;

    localparam int N             = 10;
    localparam int IDX_W         = 4;
    localparam int DB_TICKS      = 4;
    localparam int TIMEOUT_TICKS = 8;

    logic             clk;
    logic             rst_n;
    logic             sample_en;
    logic [N-1:0]     buttons;
    logic [N-1:0]     press_pulse;
    logic             sel_pending;
    logic             pair_valid;
    logic             pair_ready;
    logic [IDX_W-1:0] idx_a;
    logic [IDX_W-1:0] idx_b;
    logic             timeout;

    int checks = 0;
    int errors = 0;

    int               pulse_count [N];
    int               pulse_total;
    int               pv_cycles;
    int               hs_count;
    int               to_count;
    bit               pv_seen;
    logic [IDX_W-1:0] hs_a;
    logic [IDX_W-1:0] hs_b;

    button_pair_sel #(
        .N(N),
        .IDX_W(IDX_W),
        .DB_TICKS(DB_TICKS),
        .TIMEOUT_TICKS(TIMEOUT_TICKS)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .sample_en(sample_en),
        .buttons(buttons),
        .press_pulse(press_pulse),
        .sel_pending(sel_pending),
        .pair_valid(pair_valid),
        .pair_ready(pair_ready),
        .idx_a(idx_a),
        .idx_b(idx_b),
        .timeout(timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One-clk sample strobe every 4 clocks, changed just after the rising edge.
    initial begin
        int div;
        div = 0;
        sample_en = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            sample_en = (div == 3);
            div = (div + 1) % 4;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < N; i++) begin
                if (press_pulse[i]) begin
                    pulse_count[i]++;
                    pulse_total++;
                end
            end
            if (pair_valid) begin
                pv_seen = 1'b1;
                pv_cycles++;
                if (pair_ready) begin
                    hs_count++;
                    hs_a = idx_a;
                    hs_b = idx_b;
                end
            end
            if (timeout) to_count++;
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic clear_monitor();
        for (int i = 0; i < N; i++) pulse_count[i] = 0;
        pulse_total = 0;
        pv_cycles   = 0;
        hs_count    = 0;
        to_count    = 0;
        pv_seen     = 1'b0;
        hs_a        = '0;
        hs_b        = '0;
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic press_button(input int idx);
        bit seen;
        seen = 1'b0;
        buttons[idx] = 1'b1;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (press_pulse[idx]) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("[TB] FAIL press_%0d: pulse seen=%0d, required=1 within 40 clk", idx, seen);
        end
        wait_clks(1);
        buttons[idx] = 1'b0;
        wait_clks(30);
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({press_pulse, sel_pending, pair_valid, idx_a, idx_b, timeout} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_initial: got pulse=%h pend=%b valid=%b a=%0d b=%0d to=%b, required all 0",
                     press_pulse, sel_pending, pair_valid, idx_a, idx_b, timeout);
        end
        wait_clks(3);
        clear_monitor();
        rst_n = 1'b1;
        wait_clks(4);
        pair_ready = 1'b0;
        press_button(2);
        press_button(5);
        checks++;
        if (pair_valid !== 1'b1 || idx_a !== 4'd2 || idx_b !== 4'd5) begin
            errors++;
            $display("[TB] FAIL reset_pre_pair: got valid=%b a=%0d b=%0d, required 1/2/5", pair_valid, idx_a, idx_b);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({press_pulse, sel_pending, pair_valid, idx_a, idx_b, timeout} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_midrun: got pulse=%h pend=%b valid=%b a=%0d b=%0d to=%b, required all 0",
                     press_pulse, sel_pending, pair_valid, idx_a, idx_b, timeout);
        end
        wait_clks(3);
        clear_monitor();
        rst_n = 1'b1;
        wait_clks(400);
        checks++;
        if (pulse_total !== 0 || pv_seen !== 1'b0 || sel_pending !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_quiet: got pulses=%0d valid_seen=%0d pend=%b, required 0/0/0",
                     pulse_total, pv_seen, sel_pending);
        end
    endtask

    task automatic test_bounce();
        int lat;
        bit seen;
        clear_monitor();
        for (int t = 0; t < 10; t++) begin
            buttons[3] = 1'b1;
            wait_clks(8);
            buttons[3] = 1'b0;
            wait_clks(8);
        end
        checks++;
        if (pulse_count[3] !== 0) begin
            errors++;
            $display("[TB] FAIL bounce_reject: got %0d pulses, required 0", pulse_count[3]);
        end
        buttons[3] = 1'b1;
        lat = 0;
        seen = 1'b0;
        for (int k = 1; k <= 40 && !seen; k++) begin
            @(negedge clk);
            if (press_pulse[3]) begin
                seen = 1'b1;
                lat = k;
            end
        end
        checks++;
        if (!seen || lat < 14 || lat > 19) begin
            errors++;
            $display("[TB] FAIL bounce_latency: got %0d clk (seen=%0d), required 14..19", lat, seen);
        end
        wait_clks(30);
        buttons[3] = 1'b0;
        wait_clks(30);
        checks++;
        if (pulse_count[3] !== 1 || pulse_total !== 1) begin
            errors++;
            $display("[TB] FAIL bounce_single: got %0d pulses (total %0d), required 1", pulse_count[3], pulse_total);
        end
        checks++;
        if (sel_pending !== 1'b1 || idx_a !== 4'd3) begin
            errors++;
            $display("[TB] FAIL bounce_select: got pend=%b a=%0d, required 1/3", sel_pending, idx_a);
        end
        press_button(3);
    endtask

    task automatic test_normal_pair();
        clear_monitor();
        pair_ready = 1'b1;
        press_button(2);
        press_button(7);
        checks++;
        if (hs_count !== 1 || hs_a !== 4'd2 || hs_b !== 4'd7) begin
            errors++;
            $display("[TB] FAIL normal_pair: got count=%0d a=%0d b=%0d, required 1/2/7", hs_count, hs_a, hs_b);
        end
        checks++;
        if (pv_cycles !== 1 || pair_valid !== 1'b0 || sel_pending !== 1'b0) begin
            errors++;
            $display("[TB] FAIL normal_drop: got valid_cycles=%0d valid=%b pend=%b, required 1/0/0",
                     pv_cycles, pair_valid, sel_pending);
        end
    endtask

    task automatic test_backpressure();
        bit hold_ok;
        clear_monitor();
        pair_ready = 1'b0;
        press_button(5);
        press_button(1);
        hold_ok = 1'b1;
        buttons[9] = 1'b1;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (!(pair_valid === 1'b1 && idx_a === 4'd5 && idx_b === 4'd1)) hold_ok = 1'b0;
            if (k == 50) buttons[9] = 1'b0;
        end
        checks++;
        if (!hold_ok || hs_count !== 0) begin
            errors++;
            $display("[TB] FAIL bp_hold: got held=%0d handshakes=%0d, required 1/0", hold_ok, hs_count);
        end
        checks++;
        if (pulse_count[9] !== 1) begin
            errors++;
            $display("[TB] FAIL bp_press9_pulse: got %0d, required 1", pulse_count[9]);
        end
        wait_clks(1);
        pair_ready = 1'b1;
        for (int k = 0; k < 10 && hs_count == 0; k++) @(negedge clk);
        @(negedge clk);
        checks++;
        if (hs_count !== 1 || hs_a !== 4'd5 || hs_b !== 4'd1) begin
            errors++;
            $display("[TB] FAIL bp_handshake: got count=%0d a=%0d b=%0d, required 1/5/1", hs_count, hs_a, hs_b);
        end
        checks++;
        if (pair_valid !== 1'b0 || sel_pending !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_after: got valid=%b pend=%b, required 0/0", pair_valid, sel_pending);
        end
        wait_clks(4);
    endtask

    task automatic test_deselect_simul();
        bit seen;
        bit both;
        clear_monitor();
        pair_ready = 1'b1;
        press_button(4);
        checks++;
        if (sel_pending !== 1'b1 || idx_a !== 4'd4) begin
            errors++;
            $display("[TB] FAIL desel_first: got pend=%b a=%0d, required 1/4", sel_pending, idx_a);
        end
        press_button(4);
        checks++;
        if (sel_pending !== 1'b0 || pv_seen !== 1'b0) begin
            errors++;
            $display("[TB] FAIL desel_idle: got pend=%b valid_seen=%0d, required 0/0", sel_pending, pv_seen);
        end
        buttons[6] = 1'b1;
        buttons[8] = 1'b1;
        seen = 1'b0;
        both = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (press_pulse[6]) begin
                seen = 1'b1;
                both = press_pulse[8];
            end
        end
        checks++;
        if (!seen || !both) begin
            errors++;
            $display("[TB] FAIL simul_pulses: got pulse6=%0d pulse8=%0d, required 1/1", seen, both);
        end
        wait_clks(1);
        buttons[6] = 1'b0;
        buttons[8] = 1'b0;
        wait_clks(30);
        checks++;
        if (sel_pending !== 1'b1 || idx_a !== 4'd6) begin
            errors++;
            $display("[TB] FAIL simul_select: got pend=%b a=%0d, required 1/6", sel_pending, idx_a);
        end
        press_button(0);
        checks++;
        if (hs_count !== 1 || hs_a !== 4'd6 || hs_b !== 4'd0) begin
            errors++;
            $display("[TB] FAIL simul_pair: got count=%0d a=%0d b=%0d, required 1/6/0", hs_count, hs_a, hs_b);
        end
    endtask

    task automatic test_timeout();
        bit seen;
        clear_monitor();
        pair_ready = 1'b1;
        press_button(3);
`ifdef BUTTON_PAIR_SEL_TIMEOUT_EN
        wait_clks(40);
        checks++;
        if (to_count !== 1 || sel_pending !== 1'b0) begin
            errors++;
            $display("[TB] FAIL timeout_expire: got pulses=%0d pend=%b, required 1/0", to_count, sel_pending);
        end
        buttons[1] = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (press_pulse[1]) seen = 1'b1;
        end
        @(negedge clk);
        checks++;
        if (!seen || sel_pending !== 1'b1 || idx_a !== 4'd1) begin
            errors++;
            $display("[TB] FAIL timeout_reselect: got seen=%0d pend=%b a=%0d, required 1/1/1", seen, sel_pending, idx_a);
        end
        wait_clks(1);
        buttons[1] = 1'b0;
        wait_clks(60);
`else
        seen = 1'b0;
        wait_clks(200);
        checks++;
        if (to_count !== 0 || timeout !== 1'b0 || sel_pending !== 1'b1 || idx_a !== 4'd3) begin
            errors++;
            $display("[TB] FAIL no_timeout: got pulses=%0d pend=%b a=%0d, required 0/1/3", to_count, sel_pending, idx_a);
        end
        press_button(3);
        checks++;
        if (sel_pending !== 1'b0 || seen !== 1'b0) begin
            errors++;
            $display("[TB] FAIL no_timeout_desel: got pend=%b, required 0", sel_pending);
        end
`endif
    endtask

    initial begin
        rst_n      = 1'b0;
        buttons    = '0;
        pair_ready = 1'b0;
        clear_monitor();
        $display("[TB] starting button_pair_sel bench");
        test_reset();
        test_bounce();
        test_normal_pair();
        test_backpressure();
        test_deselect_simul();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
